// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared widths, funct codes and state encodings for the HI/LO unit
package mult_div_unit_pkg;

  localparam int MD_DATA_W    = 32;
  localparam int MD_DIV_STEPS = 32;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic md_is_long_op(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
           (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU);
  endfunction

  function automatic logic md_is_signed_op(input logic [5:0] funct);
    return (funct == FUNCT_MULT) || (funct == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - EX-stage request and HI/LO result bundle for the mult/div unit
interface mult_div_unit_if #(parameter int DATA_W = 32);

  logic              flush;
  logic              en;
  logic [5:0]        funct;
  logic [DATA_W-1:0] operand_1;
  logic [DATA_W-1:0] operand_2;
  logic              busy;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              done;

  modport master (
    output flush, en, funct, operand_1, operand_2,
    input  busy, hi, lo, done
  );

  modport slave (
    input  flush, en, funct, operand_1, operand_2,
    output busy, hi, lo, done
  );

endinterface

// File: rtl/mult_div_unit_div_iter.sv
// rtl/mult_div_unit_div_iter.sv - one unsigned restoring-divide step
module mult_div_unit_div_iter #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] divisor,
  input  logic              dividend_bit,
  output logic [DATA_W-1:0] rem_out,
  output logic              q_bit
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;

  // rem_in < divisor, so the shifted value stays below 2*divisor and the
  // extra top bit of the difference is a clean borrow flag.
  always_comb begin
    shifted = {rem_in, dividend_bit};
    diff    = shifted - {1'b0, divisor};
    q_bit   = ~diff[DATA_W];
    rem_out = q_bit ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - EX-stage HI/LO unit: 2-cycle multiply, 32-step restoring divide, MTHI/MTLO
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int DATA_W    = MD_DATA_W,
  parameter int DIV_STEPS = MD_DIV_STEPS
) (
  input  logic            clk,
  input  logic            rst,
  mult_div_unit_if.slave  md
);

  localparam int              CNT_W     = $clog2(DIV_STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

  md_state_e           state;
  logic [DATA_W-1:0]   hi_q;
  logic [DATA_W-1:0]   lo_q;
  logic [DATA_W-1:0]   opa_q;
  logic [DATA_W-1:0]   opb_q;
  logic [DATA_W-1:0]   rem_q;
  logic [2*DATA_W-1:0] product_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                is_signed_q;
  logic                is_div_q;
  logic                div_zero_q;
  logic                neg_quot_q;
  logic                neg_rem_q;

  logic                start;
  logic                start_signed;
  logic [DATA_W-1:0]   op1_mag;
  logic [DATA_W-1:0]   op2_mag;
  logic [2*DATA_W-1:0] mul_a;
  logic [2*DATA_W-1:0] mul_b;
  logic [DATA_W-1:0]   quot_final;
  logic [DATA_W-1:0]   rem_final;
  logic [DATA_W-1:0]   rem_next;
  logic                q_bit;

  always_comb begin
    start        = md.en && !md.flush && (state == MD_IDLE) && md_is_long_op(md.funct);
    start_signed = md_is_signed_op(md.funct);
    op1_mag      = (start_signed && md.operand_1[DATA_W-1]) ? -md.operand_1 : md.operand_1;
    op2_mag      = (start_signed && md.operand_2[DATA_W-1]) ? -md.operand_2 : md.operand_2;
    // Sign-extending to 64 bits makes the low 64 product bits correct for both signednesses.
    mul_a        = {{DATA_W{is_signed_q & opa_q[DATA_W-1]}}, opa_q};
    mul_b        = {{DATA_W{is_signed_q & opb_q[DATA_W-1]}}, opb_q};
    quot_final   = neg_quot_q ? -opa_q : opa_q;
    rem_final    = neg_rem_q ? -rem_q : rem_q;
  end

  // opa_q doubles as the dividend shift register: quotient bits enter at the bottom.
  mult_div_unit_div_iter #(.DATA_W(DATA_W)) u_div_iter (
    .rem_in       (rem_q),
    .divisor      (opb_q),
    .dividend_bit (opa_q[DATA_W-1]),
    .rem_out      (rem_next),
    .q_bit        (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MD_IDLE;
      hi_q        <= '0;
      lo_q        <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      rem_q       <= '0;
      product_q   <= '0;
      cnt_q       <= '0;
      is_signed_q <= 1'b0;
      is_div_q    <= 1'b0;
      div_zero_q  <= 1'b0;
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
    end else if (md.flush) begin
      state <= MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: begin
          if (start) begin
            is_signed_q <= start_signed;
            if ((md.funct == FUNCT_MULT) || (md.funct == FUNCT_MULTU)) begin
              opa_q      <= md.operand_1;
              opb_q      <= md.operand_2;
              is_div_q   <= 1'b0;
              div_zero_q <= 1'b0;
              state      <= MD_MUL;
            end else if (md.operand_2 == '0) begin
              is_div_q   <= 1'b1;
              div_zero_q <= 1'b1;
              state      <= MD_DONE;
            end else begin
              opa_q      <= op1_mag;
              opb_q      <= op2_mag;
              rem_q      <= '0;
              cnt_q      <= '0;
              neg_quot_q <= start_signed && (md.operand_1[DATA_W-1] ^ md.operand_2[DATA_W-1]);
              neg_rem_q  <= start_signed && md.operand_1[DATA_W-1];
              is_div_q   <= 1'b1;
              div_zero_q <= 1'b0;
              state      <= MD_DIV;
            end
          end else if (md.en && (md.funct == FUNCT_MTHI)) begin
            hi_q <= md.operand_1;
          end else if (md.en && (md.funct == FUNCT_MTLO)) begin
            lo_q <= md.operand_1;
          end
        end
        MD_MUL: begin
          product_q <= mul_a * mul_b;
          state     <= MD_DONE;
        end
        MD_DIV: begin
          opa_q <= {opa_q[DATA_W-2:0], q_bit};
          rem_q <= rem_next;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_STEP) begin
            state <= MD_DONE;
          end
        end
        MD_DONE: begin
          if (!div_zero_q) begin
            if (is_div_q) begin
              lo_q <= quot_final;
              hi_q <= rem_final;
            end else begin
              lo_q <= product_q[DATA_W-1:0];
              hi_q <= product_q[2*DATA_W-1:DATA_W];
            end
          end
          state <= MD_IDLE;
        end
        default: state <= MD_IDLE;
      endcase
    end
  end

  assign md.busy = (state == MD_MUL) || (state == MD_DIV) || start;
  assign md.done = (state == MD_DONE) && !md.flush;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mult_div_unit_if md_bus ();

  mult_div_unit dut (
    .clk (clk),
    .rst (rst),
    .md  (md_bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [63:0] sb_q[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic predict(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [63:0] sp;
    logic [63:0]        up;
    int                 sa;
    int                 sb;
    sa   = $signed(a);
    sb   = $signed(b);
    sa64 = sa;
    sb64 = sb;
    case (f)
      FUNCT_MULT: begin
        sp = sa64 * sb64;
        {m_hi, m_lo} = sp;
      end
      FUNCT_MULTU: begin
        up = {32'b0, a} * {32'b0, b};
        {m_hi, m_lo} = up;
      end
      FUNCT_DIV: begin
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            m_lo = 32'h8000_0000;
            m_hi = 32'h0;
          end else begin
            m_lo = 32'(sa / sb);
            m_hi = 32'(sa % sb);
          end
        end
      end
      FUNCT_DIVU: begin
        if (b != 0) begin
          m_lo = a / b;
          m_hi = a % b;
        end
      end
      FUNCT_MTHI: m_hi = a;
      FUNCT_MTLO: m_lo = a;
      default: ;
    endcase
    sb_q.push_back({m_hi, m_lo});
  endtask

  task automatic run_op(input string tag, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    int          busy_cnt;
    int          done_cnt;
    int          cyc;
    int          exp_busy;
    bit          adv;
    logic [63:0] exp;
    busy_cnt = 0;
    done_cnt = 0;
    cyc      = 0;
    adv      = 1'b0;
    exp_busy = (f == FUNCT_MULT || f == FUNCT_MULTU) ? 2 : ((b == 0) ? 1 : 33);
    predict(f, a, b);
    @(negedge clk);
    md_bus.en        = 1'b1;
    md_bus.funct     = f;
    md_bus.operand_1 = a;
    md_bus.operand_2 = b;
    while (!adv && cyc < 80) begin
      #1;
      if (md_bus.busy) busy_cnt++;
      else adv = 1'b1;
      if (md_bus.done) done_cnt++;
      @(negedge clk);
      cyc++;
    end
    md_bus.en = 1'b0;
    repeat (2) begin
      #1;
      if (md_bus.done) done_cnt++;
      @(negedge clk);
    end
    exp = sb_q.pop_front();
    check({tag, "_advanced"}, 64'(adv), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_hilo"}, {md_bus.hi, md_bus.lo}, exp);
  endtask

  task automatic mt_op(input string tag, input logic [5:0] f, input logic [31:0] v);
    logic [63:0] exp;
    predict(f, v, 32'h0);
    @(negedge clk);
    md_bus.en        = 1'b1;
    md_bus.funct     = f;
    md_bus.operand_1 = v;
    #1;
    check({tag, "_busy"}, 64'(md_bus.busy), 64'd0);
    @(negedge clk);
    md_bus.en = 1'b0;
    #1;
    exp = sb_q.pop_front();
    check({tag, "_hilo"}, {md_bus.hi, md_bus.lo}, exp);
  endtask

  initial begin
    logic [5:0]  op_tab [4];
    logic [63:0] exp;
    int          done_cnt;

    op_tab[0] = FUNCT_MULT;
    op_tab[1] = FUNCT_MULTU;
    op_tab[2] = FUNCT_DIV;
    op_tab[3] = FUNCT_DIVU;

    rst              = 1'b1;
    md_bus.flush     = 1'b0;
    md_bus.en        = 1'b0;
    md_bus.funct     = 6'h00;
    md_bus.operand_1 = '0;
    md_bus.operand_2 = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_hilo", {md_bus.hi, md_bus.lo}, 64'h0);
    check("reset_busy", 64'(md_bus.busy), 64'd0);
    check("reset_done", 64'(md_bus.done), 64'd0);
    rst = 1'b0;

    run_op("mult_neg", FUNCT_MULT, 32'hFFFF_FFFD, 32'd7);
    run_op("multu_max", FUNCT_MULTU, 32'hFFFF_FFFF, 32'd2);
    run_op("divu_100_7", FUNCT_DIVU, 32'd100, 32'd7);
    run_op("div_neg7_2", FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op("div_ovf", FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("div_pos_neg", FUNCT_DIV, 32'd1000, 32'hFFFF_FFFD);

    mt_op("mthi", FUNCT_MTHI, 32'h1234_5678);
    mt_op("mtlo", FUNCT_MTLO, 32'h9ABC_DEF0);
    run_op("div_by_zero", FUNCT_DIV, 32'd55, 32'd0);
    run_op("divu_by_zero", FUNCT_DIVU, 32'hFFFF_0000, 32'd0);

    for (int i = 0; i < 4; i++) begin
      run_op("rand_op", op_tab[$urandom_range(3)], $urandom, $urandom);
    end

    // Flush on the 10th DIV cycle: nothing commits.
    done_cnt = 0;
    @(negedge clk);
    md_bus.en        = 1'b1;
    md_bus.funct     = FUNCT_DIVU;
    md_bus.operand_1 = 32'd100;
    md_bus.operand_2 = 32'd7;
    repeat (10) begin
      #1;
      if (md_bus.done) done_cnt++;
      @(negedge clk);
    end
    md_bus.flush = 1'b1;
    md_bus.en    = 1'b0;
    #1;
    if (md_bus.done) done_cnt++;
    @(negedge clk);
    md_bus.flush = 1'b0;
    #1;
    if (md_bus.done) done_cnt++;
    sb_q.push_back({m_hi, m_lo});
    exp = sb_q.pop_front();
    check("flush_busy", 64'(md_bus.busy), 64'd0);
    repeat (40) begin
      @(negedge clk);
      #1;
      if (md_bus.done) done_cnt++;
    end
    check("flush_done_pulses", 64'(done_cnt), 64'd0);
    check("flush_hilo", {md_bus.hi, md_bus.lo}, exp);
    run_op("after_flush", FUNCT_MULTU, 32'h0001_0000, 32'h0003_0000);

    // Reset in the middle of a multiply.
    @(negedge clk);
    md_bus.en        = 1'b1;
    md_bus.funct     = FUNCT_MULT;
    md_bus.operand_1 = 32'd3;
    md_bus.operand_2 = 32'd4;
    @(negedge clk);
    rst       = 1'b1;
    md_bus.en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    m_hi = '0;
    m_lo = '0;
    check("rst_mid_mul_hilo", {md_bus.hi, md_bus.lo}, 64'h0);
    check("rst_mid_mul_busy", 64'(md_bus.busy), 64'd0);
    check("rst_mid_mul_done", 64'(md_bus.done), 64'd0);

    // MTLO immediately followed by MFLO.
    predict(FUNCT_MTLO, 32'h0000_BEEF, 32'h0);
    @(negedge clk);
    md_bus.en        = 1'b1;
    md_bus.funct     = FUNCT_MTLO;
    md_bus.operand_1 = 32'h0000_BEEF;
    #1;
    check("mtlo_busy", 64'(md_bus.busy), 64'd0);
    @(negedge clk);
    md_bus.funct     = FUNCT_MFLO;
    md_bus.operand_1 = 32'h0;
    #1;
    exp = sb_q.pop_front();
    check("mflo_lo", 64'(md_bus.lo), 64'(exp[31:0]));
    check("mflo_busy", 64'(md_bus.busy), 64'd0);
    @(negedge clk);
    md_bus.en = 1'b0;
    #1;
    check("mflo_hilo_stable", {md_bus.hi, md_bus.lo}, exp);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
